// File: rtl/jtcop_bus_resp_if.sv
// jtcop_bus_resp_if
// Bus-side signals between the 68000 address decoder and the bus-cycle responder.
//   master : the CPU/decoder side; drives strobes, selects, SDRAM ok lines and cpu_cen,
//            and receives DTACKn, act_stb, bus_err and busy.
//   slave  : the responder side (jtcop_bus_resp).
interface jtcop_bus_resp_if;
  logic       cpu_cen;
  logic       ASn;
  logic       UDSn;
  logic       LDSn;
  logic       RnW;
  logic       rom_cs;
  logic       sysram_cs;
  logic       fast_cs;
  logic       rom_ok;
  logic       ram_ok;
  logic [3:0] act_cs;
  logic       DTACKn;
  logic [3:0] act_stb;
  logic       bus_err;
  logic       busy;

  modport master (
    output cpu_cen, ASn, UDSn, LDSn, RnW, rom_cs, sysram_cs, fast_cs,
           rom_ok, ram_ok, act_cs,
    input  DTACKn, act_stb, bus_err, busy
  );

  modport slave (
    input  cpu_cen, ASn, UDSn, LDSn, RnW, rom_cs, sysram_cs, fast_cs,
           rom_ok, ram_ok, act_cs,
    output DTACKn, act_stb, bus_err, busy
  );
endinterface

// File: rtl/jtcop_bus_resp.sv
// jtcop_bus_resp
// Bus-cycle responder for the main 68000: turns decoder chip-selects into DTACKn
// with the proper wait states, converts write-action selects into one-clk pulses
// and raises a sticky bus error on hung or unmapped cycles.
// Ports:
//   rst  : asynchronous, active-high reset
//   clk  : system clock
//   bus  : jtcop_bus_resp_if.slave (strobes, selects, ok lines, cpu_cen in;
//          DTACKn, act_stb, bus_err, busy out; all outputs registered)
// Parameters:
//   WAIT_FAST : cpu_cen pulses to wait before acknowledging internal regions (0-3)
//   TIMEOUT   : clk cycles allowed in a wait state before a forced acknowledge
module jtcop_bus_resp #(
  parameter int WAIT_FAST = 0,
  parameter int TIMEOUT   = 255
) (
  input logic            rst,
  input logic            clk,
  jtcop_bus_resp_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DECODE    = 3'd1,
    ST_WAIT_FAST = 3'd2,
    ST_WAIT_SLOW = 3'd3,
    ST_ACK       = 3'd4
  } state_t;

  localparam logic [1:0] WF_LAST = 2'(WAIT_FAST - 1);
  localparam logic [7:0] TO_LIM  = 8'(TIMEOUT);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] fcnt_q, fcnt_d;
  logic       sel_rom_q, sel_rom_d;
  logic       sel_ram_q, sel_ram_d;
  logic       dtack_n_q, dtack_n_d;
  logic       busy_q, busy_d;
  logic       bus_err_q, bus_err_d;
  logic [3:0] act_stb_q, act_stb_d;

  logic       ds_act;
  logic       ok_sel;
  logic [7:0] cnt_inc;
  logic       to_hit;

  assign ds_act  = ~bus.UDSn | ~bus.LDSn;
  // Only the ok line belonging to the latched region may end a slow wait;
  // with no latched select nothing can, so the cycle runs into the timeout.
  assign ok_sel  = (sel_rom_q & bus.rom_ok) | (sel_ram_q & bus.ram_ok);
  assign cnt_inc = cnt_q + 8'd1;
  assign to_hit  = (cnt_inc == TO_LIM);

  // Next-state and registered-output decode
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    fcnt_d    = fcnt_q;
    sel_rom_d = sel_rom_q;
    sel_ram_d = sel_ram_q;
    bus_err_d = bus_err_q;
    act_stb_d = 4'b0000;
    case (state_q)
      ST_IDLE: begin
        cnt_d  = 8'd0;
        fcnt_d = 2'd0;
        if (!bus.ASn && ds_act) begin
          state_d = ST_DECODE;
          // The pulse is produced only on the IDLE->DECODE step, so a cycle
          // can never emit more than one, whatever the data strobes do later.
          if (!bus.RnW) begin
            act_stb_d = bus.act_cs;
          end else begin
            act_stb_d = 4'b0000;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DECODE: begin
        if (bus.ASn) begin
          state_d = ST_IDLE;
        end else if (bus.rom_cs || bus.sysram_cs) begin
          sel_rom_d = bus.rom_cs;
          sel_ram_d = bus.sysram_cs;
          state_d   = ST_WAIT_SLOW;
        end else if (bus.fast_cs) begin
          sel_rom_d = 1'b0;
          sel_ram_d = 1'b0;
          state_d   = (WAIT_FAST == 0) ? ST_ACK : ST_WAIT_FAST;
        end else begin
          sel_rom_d = 1'b0;
          sel_ram_d = 1'b0;
          state_d   = ST_WAIT_SLOW;
        end
      end
      ST_WAIT_FAST: begin
        if (bus.ASn) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_inc;
          if (bus.cpu_cen) begin
            fcnt_d = fcnt_q + 2'd1;
          end else begin
            fcnt_d = fcnt_q;
          end
          if (bus.cpu_cen && (fcnt_q == WF_LAST)) begin
            state_d = ST_ACK;
          end else if (to_hit) begin
            state_d   = ST_ACK;
            bus_err_d = 1'b1;
          end else begin
            state_d = ST_WAIT_FAST;
          end
        end
      end
      ST_WAIT_SLOW: begin
        if (bus.ASn) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_inc;
          // cnt_q is still zero in the entry clk: an ok seen there may be left
          // over from the previous access and is not trusted.
          if ((cnt_q != 8'd0) && ok_sel) begin
            state_d = ST_ACK;
          end else if (to_hit) begin
            state_d   = ST_ACK;
            bus_err_d = 1'b1;
          end else begin
            state_d = ST_WAIT_SLOW;
          end
        end
      end
      ST_ACK: begin
        if (bus.ASn) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ACK;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    dtack_n_d = (state_d != ST_ACK);
    busy_d    = (state_d != ST_IDLE);
  end

  // State, counters and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 8'd0;
      fcnt_q    <= 2'd0;
      sel_rom_q <= 1'b0;
      sel_ram_q <= 1'b0;
      dtack_n_q <= 1'b1;
      busy_q    <= 1'b0;
      bus_err_q <= 1'b0;
      act_stb_q <= 4'b0000;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      fcnt_q    <= fcnt_d;
      sel_rom_q <= sel_rom_d;
      sel_ram_q <= sel_ram_d;
      dtack_n_q <= dtack_n_d;
      busy_q    <= busy_d;
      bus_err_q <= bus_err_d;
      act_stb_q <= act_stb_d;
    end
  end

  assign bus.DTACKn  = dtack_n_q;
  assign bus.busy    = busy_q;
  assign bus.bus_err = bus_err_q;
  assign bus.act_stb = act_stb_q;

endmodule

// File: tb/tb_jtcop_bus_resp.sv
// tb_jtcop_bus_resp
// Drives one bus-cycle stream into two responders (WAIT_FAST=0 and WAIT_FAST=2)
// and compares every clk against a cycle-count reference model.
module tb_jtcop_bus_resp;

  localparam int TMO = 255;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cen = 1'b0;
  logic       ASn = 1'b1;
  logic       UDSn = 1'b1;
  logic       LDSn = 1'b1;
  logic       RnW = 1'b1;
  logic       rom_cs = 1'b0;
  logic       sysram_cs = 1'b0;
  logic       fast_cs = 1'b0;
  logic       rom_ok = 1'b0;
  logic       ram_ok = 1'b0;
  logic [3:0] act_cs = 4'b0000;

  int n_chk  = 0;
  int n_fail = 0;
  bit err0   = 1'b0;
  bit err1   = 1'b0;

  jtcop_bus_resp_if b0();
  jtcop_bus_resp_if b1();

  assign b0.cpu_cen = cen;       assign b1.cpu_cen = cen;
  assign b0.ASn = ASn;           assign b1.ASn = ASn;
  assign b0.UDSn = UDSn;         assign b1.UDSn = UDSn;
  assign b0.LDSn = LDSn;         assign b1.LDSn = LDSn;
  assign b0.RnW = RnW;           assign b1.RnW = RnW;
  assign b0.rom_cs = rom_cs;     assign b1.rom_cs = rom_cs;
  assign b0.sysram_cs = sysram_cs; assign b1.sysram_cs = sysram_cs;
  assign b0.fast_cs = fast_cs;   assign b1.fast_cs = fast_cs;
  assign b0.rom_ok = rom_ok;     assign b1.rom_ok = rom_ok;
  assign b0.ram_ok = ram_ok;     assign b1.ram_ok = ram_ok;
  assign b0.act_cs = act_cs;     assign b1.act_cs = act_cs;

  jtcop_bus_resp #(.WAIT_FAST(0), .TIMEOUT(TMO)) u0 (.rst(rst), .clk(clk), .bus(b0));
  jtcop_bus_resp #(.WAIT_FAST(2), .TIMEOUT(TMO)) u1 (.rst(rst), .clk(clk), .bus(b1));

  always #5 clk = ~clk;

  // Safety net so the run always ends
  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ok line value during the clk that starts at cycle-relative edge rel
  function automatic bit ok_val(input int rel, input int lo, input int hi);
    return (rel < lo) || (rel >= hi);
  endfunction

  // cpu_cen: one clk in every four, phase chosen per cycle
  function automatic bit cen_val(input int rel, input int ph);
    return ((rel + ph) % 4) == 0;
  endfunction

  // Edge (relative to the strobe-sampling edge) at which DTACKn goes low.
  function automatic int model_ack(input int kind, input int wf, input int lo,
                                   input int hi, input int ph, output bit to);
    int res;
    int n;
    res = -1;
    n   = 0;
    to  = 1'b0;
    if (kind == 0) begin
      if (wf == 0) begin
        res = 1;
      end else begin
        for (int r = 1; r < 64; r++) begin
          if (res < 0 && cen_val(r, ph)) begin
            n++;
            if (n == wf) res = r + 1;
          end
        end
      end
    end else begin
      if (kind == 1 || kind == 2) begin
        for (int e = 3; e <= TMO + 1; e++) begin
          if (res < 0 && ok_val(e - 1, lo, hi)) res = e;
        end
      end
      if (res < 0) begin
        to  = 1'b1;
        res = TMO + 1;
      end
    end
    return res;
  endfunction

  task automatic drive_oks(input int kind, input int rel, input int lo, input int hi);
    bit m;
    m = ok_val(rel, lo, hi);
    rom_ok = (kind == 1) ? m : 1'b1;
    ram_ok = (kind == 2) ? m : 1'b1;
  endtask

  task automatic release_bus();
    ASn = 1'b1; UDSn = 1'b1; LDSn = 1'b1;
    rom_cs = 1'b0; sysram_cs = 1'b0; fast_cs = 1'b0; cen = 1'b0;
  endtask

  // kind: 0 fast, 1 rom, 2 sysram, 3 unmapped
  task automatic bus_cycle(input int kind, input bit rnw, input logic [3:0] act,
                           input int lo, input int hi, input int ph, input int hold,
                           input int abort_req, input int ds_tog, input bit rst_mode);
    int a0, a1, rel_r, amin, u;
    bit t0, t1, ab;
    bit edt0, edt1, ebusy, ee0, ee1;
    logic [3:0] eact;
    a0 = model_ack(kind, 0, lo, hi, ph, t0);
    a1 = model_ack(kind, 2, lo, hi, ph, t1);
    amin = (a0 < a1) ? a0 : a1;
    ab = (abort_req >= 0);
    if (ab) rel_r = (abort_req < amin) ? abort_req : amin - 1;
    else    rel_r = ((a0 > a1) ? a0 : a1) + hold;

    ASn = 1'b0; RnW = rnw; act_cs = act;
    rom_cs = (kind == 1); sysram_cs = (kind == 2); fast_cs = (kind == 0);
    if (ds_tog >= 0) begin
      UDSn = 1'b0; LDSn = 1'b1;
    end else begin
      u = int'($urandom_range(0, 2));
      UDSn = (u == 2); LDSn = (u == 1);
    end
    drive_oks(kind, -1, lo, hi);
    cen = cen_val(-1, ph);

    for (int rel = 0; rel <= rel_r + 1; rel++) begin
      tick();
      edt0  = !(!ab && rel >= a0 && rel <= rel_r);
      edt1  = !(!ab && rel >= a1 && rel <= rel_r);
      ebusy = (rel <= rel_r);
      eact  = (rel == 0 && !rnw) ? act : 4'b0000;
      ee0   = err0 | (t0 && !ab && rel >= a0);
      ee1   = err1 | (t1 && !ab && rel >= a1);
      chk("dtack0", {7'd0, b0.DTACKn}, {7'd0, edt0});
      chk("dtack1", {7'd0, b1.DTACKn}, {7'd0, edt1});
      chk("busy0", {7'd0, b0.busy}, {7'd0, ebusy});
      chk("busy1", {7'd0, b1.busy}, {7'd0, ebusy});
      chk("act0", {4'd0, b0.act_stb}, {4'd0, eact});
      chk("act1", {4'd0, b1.act_stb}, {4'd0, eact});
      chk("err0", {7'd0, b0.bus_err}, {7'd0, ee0});
      chk("err1", {7'd0, b1.bus_err}, {7'd0, ee1});
      if (rel == rel_r) begin
        if (rst_mode) begin
          #2 rst = 1'b1;
          #1;
          chk("rst_dtack0", {7'd0, b0.DTACKn}, 8'd1);
          chk("rst_dtack1", {7'd0, b1.DTACKn}, 8'd1);
          chk("rst_busy0", {7'd0, b0.busy}, 8'd0);
          chk("rst_busy1", {7'd0, b1.busy}, 8'd0);
          release_bus();
          #1 rst = 1'b0;
          err0 = 1'b0;
          err1 = 1'b0;
          break;
        end else begin
          release_bus();
        end
      end else begin
        drive_oks(kind, rel, lo, hi);
        cen = cen_val(rel, ph);
        if (ds_tog >= 0 && rel >= ds_tog && rel <= ds_tog + 3) begin
          UDSn = ((rel - ds_tog) % 2) == 0;
        end
      end
    end
    if (!rst_mode) begin
      err0 = err0 | (t0 && !ab);
      err1 = err1 | (t1 && !ab);
    end
    tick();
    chk("idle_dtack0", {7'd0, b0.DTACKn}, 8'd1);
    chk("idle_busy1", {7'd0, b1.busy}, 8'd0);
    chk("idle_err0", {7'd0, b0.bus_err}, {7'd0, err0});
    chk("idle_err1", {7'd0, b1.bus_err}, {7'd0, err1});
  endtask

  initial begin
    int kind, lo, ab_req;
    // reset state
    tick();
    tick();
    chk("rst_dtack", {7'd0, b0.DTACKn}, 8'd1);
    chk("rst_busy", {7'd0, b0.busy}, 8'd0);
    chk("rst_act", {4'd0, b0.act_stb}, 8'd0);
    chk("rst_err", {7'd0, b1.bus_err}, 8'd0);
    rst = 1'b0;
    tick();
    tick();

    // fast read: no pulse on reads even with act_cs asserted
    bus_cycle(0, 1'b1, 4'b1111, 0, 0, 1, 2, -1, -1, 1'b0);
    // ROM read: stale ok high over the entry clk, low 10 clk, then high
    bus_cycle(1, 1'b1, 4'b0000, 2, 12, 2, 1, -1, -1, 1'b0);
    // sysram read: ok present from entry, accepted at the first trusted sample
    bus_cycle(2, 1'b1, 4'b0000, -1, 1, 3, 0, -1, -1, 1'b0);
    // action write vint_clr, long hold with UDSn toggling twice
    bus_cycle(0, 1'b0, 4'b0010, 0, 0, 4, 15, -1, 3, 1'b0);
    // TAS-style write to ROM region: DS toggles inside ACK
    bus_cycle(1, 1'b0, 4'b0001, -1, 4, 1, 6, -1, 6, 1'b0);
    // unmapped access runs into the timeout; error must stay sticky
    bus_cycle(3, 1'b1, 4'b0000, 0, 0, 1, 2, -1, -1, 1'b0);
    bus_cycle(0, 1'b1, 4'b0000, 0, 0, 2, 1, -1, -1, 1'b0);
    // abort during WAIT_SLOW, and abort straight out of DECODE
    bus_cycle(2, 1'b1, 4'b0000, -1, 30, 1, 0, 5, -1, 1'b0);
    bus_cycle(0, 1'b0, 4'b0100, 0, 0, 1, 0, 0, -1, 1'b0);
    // reset pulse while acknowledging clears everything including bus_err
    bus_cycle(1, 1'b1, 4'b0000, -1, 3, 1, 3, -1, -1, 1'b1);

    // randomized cycles
    for (int i = 0; i < 14; i++) begin
      kind   = int'($urandom_range(0, 9));
      kind   = (kind == 9) ? 3 : kind % 3;
      lo     = int'($urandom_range(0, 4)) - 1;
      ab_req = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 8)) : -1;
      bus_cycle(kind, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                lo, lo + int'($urandom_range(0, 12)), int'($urandom_range(1, 4)),
                int'($urandom_range(0, 3)), ab_req,
                ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 5)) : -1, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
